// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: taps the MEM/WB register-file write port, keeps a shadow
// copy of the architectural registers and logs every non-zero-register write
// into a back-pressured trace FIFO drained through out_valid/out_ready.
// Optional build macro: WB_TRACE_STAMP_EN adds a free-running cycle counter,
// a per-event stamp and the out_stamp port.
module wb_trace_monitor #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int PC_W    = 5,
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_we,
    input  logic [REG_AW-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic [PC_W-1:0]            wb_pc,
    input  logic                       clear,
    input  logic [REG_AW-1:0]          shadow_raddr,
    output logic [DATA_W-1:0]          shadow_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REG_AW-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic [PC_W-1:0]            out_pc,
`ifdef WB_TRACE_STAMP_EN
    output logic [STAMP_W-1:0]         out_stamp,
`endif
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << REG_AW;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_trace_monitor: DEPTH must be a power of two >= 2");
    end
    if (STAMP_W < 1) begin : g_bad_stamp
        $error("wb_trace_monitor: STAMP_W must be >= 1");
    end

    logic [DATA_W-1:0] shadow_q [NREG];
    logic [DATA_W-1:0] rdata_q;

    logic [REG_AW-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [PC_W-1:0]   mem_pc_q   [DEPTH];
`ifdef WB_TRACE_STAMP_EN
    logic [STAMP_W-1:0] mem_stamp_q [DEPTH];
    logic [STAMP_W-1:0] stamp_q;
`endif

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_q, drop_d;

    logic log_req, full, valid, pop, push, drop;

    // Classify this cycle's write and decide push / pop / drop.
    always_comb begin
        log_req = wb_we && (wb_addr != '0);
        full    = (count_q == CW'(DEPTH));
        valid   = (count_q != '0);
        pop     = valid && out_ready && !clear;
        push    = log_req && (!full || pop) && !clear;
        drop    = log_req && full && !pop && !clear;
    end

    // Next-state for pointers, occupancy and drop bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    // Shadow register file and its registered read port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) shadow_q[REG_AW'(i)] <= '0;
            rdata_q <= '0;
        end else begin
            if (log_req) shadow_q[wb_addr] <= wb_data;
            rdata_q <= shadow_q[shadow_raddr];
        end
    end

    // Trace FIFO storage; cleared on reset so the head outputs read 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_addr_q[PW'(i)] <= '0;
                mem_data_q[PW'(i)] <= '0;
                mem_pc_q[PW'(i)]   <= '0;
`ifdef WB_TRACE_STAMP_EN
                mem_stamp_q[PW'(i)] <= '0;
`endif
            end
        end else if (push) begin
            mem_addr_q[wr_ptr_q] <= wb_addr;
            mem_data_q[wr_ptr_q] <= wb_data;
            mem_pc_q[wr_ptr_q]   <= wb_pc;
`ifdef WB_TRACE_STAMP_EN
            mem_stamp_q[wr_ptr_q] <= stamp_q;
`endif
        end
    end

    // FIFO control state and error counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

`ifdef WB_TRACE_STAMP_EN
    // Free-running cycle counter; only reset clears it, clear does not.
    always_ff @(posedge clk) begin
        if (!reset) stamp_q <= '0;
        else        stamp_q <= stamp_q + STAMP_W'(1);
    end

    assign out_stamp = mem_stamp_q[rd_ptr_q];
`endif

    assign shadow_rdata = rdata_q;
    assign out_valid    = valid;
    assign out_addr     = mem_addr_q[rd_ptr_q];
    assign out_data     = mem_data_q[rd_ptr_q];
    assign out_pc       = mem_pc_q[rd_ptr_q];
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Scoreboard bench for wb_trace_monitor (default parameters, DEPTH=8).
// Stimulus pushes hand-computed expected events; a negedge monitor pops and
// compares whenever the DUT hands over an entry.
module tb_wb_trace_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  wb_pc;
    logic        clear;
    logic [4:0]  shadow_raddr;
    logic [31:0] shadow_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic [4:0]  out_pc;
`ifdef WB_TRACE_STAMP_EN
    logic [15:0] out_stamp;
`endif
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  pc;
        logic        chk_stamp;
        logic [15:0] stamp;
    } ev_t;

    ev_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    wb_trace_monitor #(.DATA_W(32), .REG_AW(5), .PC_W(5), .DEPTH(8), .STAMP_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .clear        (clear),
        .shadow_raddr (shadow_raddr),
        .shadow_rdata (shadow_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .out_pc       (out_pc),
`ifdef WB_TRACE_STAMP_EN
        .out_stamp    (out_stamp),
`endif
        .count        (count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [4:0] p,
                      input bit logged, input bit chk_st = 1'b0, input logic [15:0] st = '0);
        ev_t e;
        wb_we = 1'b1; wb_addr = a; wb_data = d; wb_pc = p;
        if (logged) begin
            e.addr = a; e.data = d; e.pc = p; e.chk_stamp = chk_st; e.stamp = st;
            sb.push_back(e);
        end
        step();
        wb_we = 1'b0;
    endtask

    task automatic rd_shadow(input logic [4:0] a, input logic [31:0] exp, input string name);
        shadow_raddr = a;
        step();
        check(name, shadow_rdata, exp);
    endtask

    // Monitor: a handshake seen mid-cycle is a pop at the next edge.
    always @(negedge clk) begin
        if (reset && !clear && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got addr %0d data 0x%0h, expected nothing", out_addr, out_data);
            end else begin
                ev_t e;
                bit bad;
                e = sb.pop_front();
                bad = (out_addr !== e.addr) || (out_data !== e.data) || (out_pc !== e.pc);
`ifdef WB_TRACE_STAMP_EN
                if (e.chk_stamp && out_stamp !== e.stamp) bad = 1'b1;
`endif
                if (bad) begin
                    n_fail++;
                    $display("FAIL pop_entry: got addr %0d data 0x%0h pc %0d, expected addr %0d data 0x%0h pc %0d",
                             out_addr, out_data, out_pc, e.addr, e.data, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; wb_pc = '0;
        clear = 1'b0; shadow_raddr = '0; out_ready = 1'b0;
        step(); step(); step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop", 32'(drop_count), 0);
        check("rst_addr", 32'(out_addr), 0);
        check("rst_data", out_data, 0);
        check("rst_rdata", shadow_rdata, 0);

        // Single write after reset.
        reset = 1'b1;
        wr(5'd1, 32'h0000_0FFF, 5'd4, 1);
        check("w1_valid", 32'(out_valid), 1);
        check("w1_count", 32'(count), 1);
        check("w1_addr", 32'(out_addr), 1);
        check("w1_data", out_data, 32'h0FFF);
        check("w1_pc", 32'(out_pc), 4);
        rd_shadow(5'd1, 32'h0000_0FFF, "shadow1");
        // Same-cycle read returns the old value, next read the new one.
        shadow_raddr = 5'd2;
        wr(5'd2, 32'h22, 5'd8, 1);
        check("shadow2_old", shadow_rdata, 0);
        rd_shadow(5'd2, 32'h22, "shadow2_new");
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        check("drain1_count", 32'(count), 0);

        // Register 0 filter.
        wr(5'd0, 32'hDEAD_BEEF, 5'd12, 0);
        check("r0_count", 32'(count), 0);
        rd_shadow(5'd0, 0, "shadow0");

        // Overflow: 10 writes into 8 slots.
        for (int i = 1; i <= 10; i++)
            wr(5'(i), 32'h100 + 32'(i), 5'(i), i <= 8);
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_drop", 32'(drop_count), 2);
        rd_shadow(5'd10, 32'h10A, "shadow10");

        // Push and pop together while full.
        out_ready = 1'b1;
        wr(5'd11, 32'hB0B, 5'd11, 1);
        out_ready = 1'b0;
        check("pp_count", 32'(count), 8);
        check("pp_drop", 32'(drop_count), 2);
        out_ready = 1'b1;
        repeat (9) step();
        out_ready = 1'b0;
        check("pp_drain_count", 32'(count), 0);
        check("pp_sb_empty", 32'(sb.size()), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Clear with five entries pending; the same-cycle write is discarded.
        for (int i = 12; i <= 16; i++)
            wr(5'(i), 32'h200 + 32'(i), 5'(i), 1);
        check("clr_pre_count", 32'(count), 5);
        sb.delete();
        clear = 1'b1;
        wr(5'd17, 32'h177, 5'd17, 0);
        clear = 1'b0;
        check("clr_count", 32'(count), 0);
        check("clr_overflow", 32'(overflow), 0);
        check("clr_drop", 32'(drop_count), 0);
        check("clr_valid", 32'(out_valid), 0);
        rd_shadow(5'd16, 32'h210, "clr_shadow16");
        rd_shadow(5'd17, 32'h177, "clr_shadow17");
        rd_shadow(5'd10, 32'h10A, "clr_shadow10");

        // Reset with three entries pending.
        for (int i = 1; i <= 3; i++)
            wr(5'(i), 32'h300 + 32'(i), 5'(i), 1);
        check("rst2_pre_count", 32'(count), 3);
        sb.delete();
        reset = 1'b0;
        step();
        check("rst2_valid", 32'(out_valid), 0);
        check("rst2_count", 32'(count), 0);
        reset = 1'b1;
`ifdef WB_TRACE_STAMP_EN
        // Stamp counter is 0 in the first cycle after release.
        step(); step(); step();
        wr(5'd5, 32'h55, 5'd5, 1, 1'b1, 16'd3);
        step(); step(); step();
        wr(5'd6, 32'h66, 5'd6, 1, 1'b1, 16'd7);
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        check("stamp_sb_empty", 32'(sb.size()), 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
`endif
        for (int i = 0; i < 32; i++)
            rd_shadow(5'(i), 0, "rst2_shadow");

        check("final_sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
